// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose: raster timing generator for a VGA-style display. A prescaler
// divides Clk down to the pixel rate. Horizontal and vertical counters
// walk the full raster (visible area, front porch, sync and back porch).
// The sync, blanking and position outputs are registered so that all of
// them change in the same Clk cycle.
//
// Optional feature: define VGA_FRAME_TICK_EN to get a one-Clk Frame pulse
// at the start of every frame. Without it, Frame is tied to 0.
//
// Parameters:
//   CLK_DIV                         Clk cycles per pixel (1..16)
//   H_ACTIVE, H_FP, H_SYNC, H_BP    horizontal timing, in pixels
//   V_ACTIVE, V_FP, V_SYNC, V_BP    vertical timing, in lines
//
// Ports:
//   Clk     in   single clock, rising edge
//   Reset   in   asynchronous reset, active low
//   PixEn   out  one-Clk pulse per pixel period
//   Hcount  out  horizontal position, 0..H_TOTAL-1
//   Vcount  out  visible line number; 0 outside the visible lines
//   Hsync   out  horizontal sync, active low
//   Vsync   out  vertical sync, active low
//   Active  out  high inside the visible window
//   Frame   out  one-Clk pulse when the raster wraps to (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       PixEn,
    output logic [9:0] Hcount,
    output logic [8:0] Vcount,
    output logic       Hsync,
    output logic       Vsync,
    output logic       Active,
    output logic       Frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // A prescaler for CLK_DIV=1 still needs one bit. That bit stays at 0.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [PW-1:0] p_q, p_d;
    logic          pix_q, pix_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic [8:0]    vcnt_q, vcnt_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          act_q, act_d;
    logic          h_wrap, v_wrap;

    always_comb begin
        p_d    = (p_q == P_LAST) ? '0 : p_q + PW'(1);
        // PixEn is registered from the next prescaler value. It is therefore
        // high exactly in the cycle in which the prescaler holds CLK_DIV-1.
        pix_d  = (p_d == P_LAST);

        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);

        h_d    = h_q;
        v_d    = v_q;
        vcnt_d = vcnt_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        act_d  = act_q;

        if (pix_q) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = v_wrap ? 10'd0 : v_q + 10'd1;
            end
            // Outputs are decoded from the next counter values. This lets
            // them land in the same edge as the counters themselves.
            vcnt_d = (v_d < V_ACT) ? v_d[8:0] : 9'd0;
            hs_d   = !((h_d >= HS_BEG) && (h_d < HS_END));
            vs_d   = !((v_d >= VS_BEG) && (v_d < VS_END));
            act_d  = (h_d < H_ACT) && (v_d < V_ACT);
        end
    end

    // Active is reset to 0 even though (0,0) lies in the visible window. The
    // first visible pixel after reset is therefore reported at (1,0).
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            p_q    <= '0;
            pix_q  <= 1'b0;
            h_q    <= 10'd0;
            v_q    <= 10'd0;
            vcnt_q <= 9'd0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            act_q  <= 1'b0;
        end else begin
            p_q    <= p_d;
            pix_q  <= pix_d;
            h_q    <= h_d;
            v_q    <= v_d;
            vcnt_q <= vcnt_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            act_q  <= act_d;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic frame_q;

    // Frame is a single-Clk strobe. It is cleared on the next edge even if
    // PixEn is low then, so it never stretches across a pixel period.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_q <= 1'b0;
        end else begin
            frame_q <= pix_q && h_wrap && v_wrap;
        end
    end

    assign Frame = frame_q;
`else
    assign Frame = 1'b0;
`endif

    assign PixEn  = pix_q;
    assign Hcount = h_q;
    assign Vcount = vcnt_q;
    assign Hsync  = hs_q;
    assign Vsync  = vs_q;
    assign Active = act_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. It runs three instances side by side:
//   0: default 640x480 timing, CLK_DIV=4
//   1: small raster, CLK_DIV=1
//   2: small raster, CLK_DIV=3
// A reference model derives every output from two numbers: the Clk edges
// since reset release and the pixels elapsed. Literal checkpoints pin the
// model. Random reset pulses exercise the asynchronous restart.
module tb_vga_timing_gen;

    localparam int NI = 3;
    localparam int CD [NI] = '{4, 1, 3};
    localparam int HA [NI] = '{640, 10, 8};
    localparam int HF [NI] = '{16, 2, 1};
    localparam int HS [NI] = '{96, 3, 2};
    localparam int HB [NI] = '{48, 2, 3};
    localparam int VA [NI] = '{480, 5, 4};
    localparam int VF [NI] = '{10, 1, 2};
    localparam int VS [NI] = '{2, 2, 1};
    localparam int VB [NI] = '{33, 1, 2};
`ifdef VGA_FRAME_TICK_EN
    localparam bit FRAME_ON = 1'b1;
`else
    localparam bit FRAME_ON = 1'b0;
`endif

    logic                Clk;
    logic [NI-1:0]       rstn;
    logic [NI-1:0]       pix, hs, vs, act, frm;
    logic [NI-1:0][9:0]  hc;
    logic [NI-1:0][8:0]  vc;

    int nchk = 0;
    int nerr = 0;
    int k [NI];
    int n [NI];
    bit fe [NI];
    int ecnt = 0;
    bit rel = 1'b0;

    vga_timing_gen #(.CLK_DIV(4), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                     .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33)) u_dut0 (
        .Clk(Clk), .Reset(rstn[0]), .PixEn(pix[0]), .Hcount(hc[0]), .Vcount(vc[0]),
        .Hsync(hs[0]), .Vsync(vs[0]), .Active(act[0]), .Frame(frm[0]));

    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_dut1 (
        .Clk(Clk), .Reset(rstn[1]), .PixEn(pix[1]), .Hcount(hc[1]), .Vcount(vc[1]),
        .Hsync(hs[1]), .Vsync(vs[1]), .Active(act[1]), .Frame(frm[1]));

    vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(2)) u_dut2 (
        .Clk(Clk), .Reset(rstn[2]), .PixEn(pix[2]), .Hcount(hc[2]), .Vcount(vc[2]),
        .Hsync(hs[2]), .Vsync(vs[2]), .Active(act[2]), .Frame(frm[2]));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic int htot(input int i);
        return HA[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int vtot(input int i);
        return VA[i] + VF[i] + VS[i] + VB[i];
    endfunction

    // PixEn is high after edge kk iff kk is congruent to CLK_DIV-1 mod CLK_DIV.
    function automatic bit pix_at(input int i, input int kk);
        return (kk >= 1) && ((kk % CD[i]) == CD[i] - 1);
    endfunction

    task automatic chk(input string nm, input int i, input int a, input int e);
        nchk++;
        if (a != e) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", nm, i, a, e, $time);
        end
    endtask

    // Compares all outputs of instance i against the model state (nn, kk, ff).
    task automatic chk_all(input string tag, input int i, input int nn, input int kk, input bit ff);
        int h, v;
        h = nn % htot(i);
        v = (nn / htot(i)) % vtot(i);
        chk({tag, "PixEn"},  i, int'(pix[i]), int'(pix_at(i, kk)));
        chk({tag, "Hcount"}, i, int'(hc[i]), h);
        chk({tag, "Vcount"}, i, int'(vc[i]), (v < VA[i]) ? v : 0);
        chk({tag, "Active"}, i, int'(act[i]), int'(nn > 0 && h < HA[i] && v < VA[i]));
        chk({tag, "Hsync"},  i, int'(hs[i]),
            int'(!(h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i])));
        chk({tag, "Vsync"},  i, int'(vs[i]),
            int'(!(v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i])));
        chk({tag, "Frame"},  i, int'(frm[i]), int'(FRAME_ON && ff));
    endtask

    // Model state: k counts edges since release and n counts pixels elapsed.
    always @(posedge Clk) begin
        if (rel) ecnt <= ecnt + 1;
        for (int i = 0; i < NI; i++) begin
            if (!rstn[i]) begin
                k[i]  <= 0;
                n[i]  <= 0;
                fe[i] <= 1'b0;
            end else begin
                k[i] <= k[i] + 1;
                if (pix_at(i, k[i])) begin
                    n[i]  <= n[i] + 1;
                    fe[i] <= ((n[i] + 1) % (htot(i) * vtot(i))) == 0;
                end else begin
                    fe[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge Clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rstn[i]) chk_all("rst_", i, 0, 0, 1'b0);
            else          chk_all("", i, n[i], k[i], fe[i]);
        end
    end

    task automatic at_edge(input int e);
        while (ecnt < e) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic lit(input string nm, input int i, input int a, input int e);
        chk({"lit_", nm}, i, a, e);
    endtask

    initial begin
        rstn = '0;
        repeat (3) @(posedge Clk);
        #3;
        rstn = '1;
        rel  = 1'b1;

        at_edge(1);    lit("pix_div1", 1, int'(pix[1]), 1);
        at_edge(2);    lit("hc_div1", 1, int'(hc[1]), 1);
                       lit("act_div1", 1, int'(act[1]), 1);
        at_edge(3);    lit("pix_first", 0, int'(pix[0]), 1);
                       lit("hc_hold", 0, int'(hc[0]), 0);
        at_edge(4);    lit("hc_1", 0, int'(hc[0]), 1);
                       lit("act_first", 0, int'(act[0]), 1);
                       lit("pix_low", 0, int'(pix[0]), 0);
        at_edge(8);    lit("hc_2", 0, int'(hc[0]), 2);
        at_edge(13);   lit("hs_small", 1, int'(hs[1]), 0);
        at_edge(18);   lit("hwrap_small", 1, int'(hc[1]), 0);
                       lit("vc_small", 1, int'(vc[1]), 1);
        at_edge(86);   lit("vc_blank", 1, int'(vc[1]), 0);
                       lit("act_blank", 1, int'(act[1]), 0);
        at_edge(102);  lit("vs_before", 1, int'(vs[1]), 1);
        at_edge(103);  lit("vs_low", 1, int'(vs[1]), 0);
        at_edge(154);  lit("frame", 1, int'(frm[1]), int'(FRAME_ON));
                       lit("frame_hc", 1, int'(hc[1]), 0);
        at_edge(155);  lit("frame_end", 1, int'(frm[1]), 0);
        at_edge(2559); lit("act_639", 0, int'(act[0]), 1);
        at_edge(2560); lit("act_640", 0, int'(act[0]), 0);
                       lit("hc_640", 0, int'(hc[0]), 640);
        at_edge(2623); lit("hs_655", 0, int'(hs[0]), 1);
        at_edge(2624); lit("hs_656", 0, int'(hs[0]), 0);
        at_edge(3007); lit("hs_751", 0, int'(hs[0]), 0);
        at_edge(3008); lit("hs_752", 0, int'(hs[0]), 1);
        at_edge(3199); lit("hc_799", 0, int'(hc[0]), 799);
        at_edge(3200); lit("hwrap", 0, int'(hc[0]), 0);
                       lit("vc_1", 0, int'(vc[0]), 1);

        // Mid-line reset on the default raster at (h,v)=(400,1). The outputs
        // must collapse at once, without waiting for a Clk edge.
        at_edge(4800);
        #2;
        lit("pre_rst_hc", 0, int'(hc[0]), 400);
        rstn[0] = 1'b0;
        #1;
        lit("async_hc", 0, int'(hc[0]), 0);
        lit("async_vc", 0, int'(vc[0]), 0);
        lit("async_act", 0, int'(act[0]), 0);
        lit("async_hs", 0, int'(hs[0]), 1);
        lit("async_vs", 0, int'(vs[0]), 1);
        repeat (2) @(posedge Clk);
        #3;
        rstn[0] = 1'b1;

        for (int it = 0; it < 30; it++) begin
            int i, w, hd;
            i  = $urandom_range(0, NI - 1);
            w  = $urandom_range(1, 500);
            hd = $urandom_range(1, 4);
            repeat (w) @(posedge Clk);
            #3;
            rstn[i] = 1'b0;
            #1;
            chk_all("async_", i, 0, 0, 1'b0);
            repeat (hd) @(posedge Clk);
            #3;
            rstn[i] = 1'b1;
        end

        repeat (2000) @(posedge Clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
